// File: rtl/mem_responder_32x8.sv
// rtl/mem_responder_32x8.sv - 32x8 synchronous RAM responder with per-word valid bitmap and clear sweep
//
// Ports:
//   clock    in   1       rising-edge clock
//   reset    in   1       asynchronous active-high reset
//   req      in   1       request strobe, sampled only while busy=0
//   wren     in   1       1 = write, 0 = read (qualified by req)
//   address  in   ADDR_W  word address (qualified by req)
//   data     in   DATA_W  write data (qualified by req & wren)
//   clr      in   1       start clear sweep, sampled only while busy=0; wins over req
//   q        out  DATA_W  read / write-through data, holds between acks
//   valid    out  1       valid bit of the last word accessed, holds between acks
//   ack      out  1       one-cycle completion pulse
//   busy     out  1       read or sweep in progress; new req/clr ignored
//   err      out  1       one-cycle pulse with ack for a rejected write
//
// Optional feature: define RAM_WP_EN for write-once protection. A write to a
// word whose valid bit is set is rejected (mem/vbit unchanged), the old value
// is read through on q, and ack+err pulse together. Without it err stays 0.

module mem_responder_32x8 #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req,
    input  logic              wren,
    input  logic [ADDR_W-1:0] address,
    input  logic [DATA_W-1:0] data,
    input  logic              clr,
    output logic [DATA_W-1:0] q,
    output logic              valid,
    output logic              ack,
    output logic              busy,
    output logic              err
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]    vbit;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   idx;

    logic                wr_block;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;

`ifdef RAM_WP_EN
    // A word becomes read-only once written; only a sweep or reset frees it.
    assign wr_block = vbit[address];
`else
    assign wr_block = 1'b0;
`endif

    // Single RAM write port shared by host writes and the clear sweep.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = address;
        mem_wdata = data;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (!clr && req && wren && !wr_block) begin
                        mem_we = 1'b1;
                    end
                end
                CLEAR: begin
                    mem_we    = 1'b1;
                    mem_waddr = idx;
                    mem_wdata = '0;
                end
                default: begin
                    mem_we = 1'b0;
                end
            endcase
        end
    end

    // RAM contents are not reset; the valid bitmap masks stale data.
    always_ff @(posedge clock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            vbit    <= '0;
            rd_addr <= '0;
            idx     <= '0;
            q       <= '0;
            valid   <= 1'b0;
            ack     <= 1'b0;
            busy    <= 1'b0;
            err     <= 1'b0;
        end else begin
            ack <= 1'b0;
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        // A request in the same cycle is dropped without ack.
                        state <= CLEAR;
                        busy  <= 1'b1;
                        idx   <= '0;
                    end else if (req && wren) begin
                        ack   <= 1'b1;
                        valid <= 1'b1;
                        if (wr_block) begin
                            q   <= mem[address];
                            err <= 1'b1;
                        end else begin
                            q             <= data;
                            vbit[address] <= 1'b1;
                        end
                    end else if (req) begin
                        state   <= READ;
                        busy    <= 1'b1;
                        rd_addr <= address;
                    end
                end
                READ: begin
                    q     <= mem[rd_addr];
                    valid <= vbit[rd_addr];
                    ack   <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                CLEAR: begin
                    vbit[idx] <= 1'b0;
                    // idx wraps naturally from DEPTH-1 back to 0.
                    idx       <= idx + 1'b1;
                    if (idx == ADDR_W'(DEPTH - 1)) begin
                        ack   <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_responder_32x8.sv
// tb/tb_mem_responder_32x8.sv - table-driven self-checking bench for mem_responder_32x8
module tb_mem_responder_32x8;

    logic       clock = 1'b0;
    logic       reset;
    logic       req;
    logic       wren;
    logic [4:0] address;
    logic [7:0] data;
    logic       clr;
    logic [7:0] q;
    logic       valid;
    logic       ack;
    logic       busy;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_responder_32x8 dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .wren    (wren),
        .address (address),
        .data    (data),
        .clr     (clr),
        .q       (q),
        .valid   (valid),
        .ack     (ack),
        .busy    (busy),
        .err     (err)
    );

    always #5 clock = ~clock;

`ifdef RAM_WP_EN
    localparam logic       WP = 1'b1;
`else
    localparam logic       WP = 1'b0;
`endif

    typedef struct {
        logic       wr;
        logic [4:0] a;
        logic [7:0] d;
        logic       chk_q;
        logic [7:0] eq;
        logic       ev;
        logic       ee;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One request; write acks after edge k, read acks after edge k+1.
    task automatic do_op(input string name, input logic w, input logic [4:0] a, input logic [7:0] d);
        @(negedge clock);
        req = 1'b1; wren = w; address = a; data = d;
        @(posedge clock); #1;
        req = 1'b0; wren = 1'b0;
        if (w) begin
            chk({name, " wr ack"}, ack, 1);
            chk({name, " wr busy"}, busy, 0);
        end else begin
            chk({name, " rd busy k"}, busy, 1);
            chk({name, " rd no early ack"}, ack, 0);
            @(posedge clock); #1;
            chk({name, " rd ack"}, ack, 1);
            chk({name, " rd busy low"}, busy, 0);
        end
    endtask

    // Pulse clr (optionally with a write request) and measure the sweep.
    task automatic do_clear(input string name, input logic with_req);
        int bcnt;
        int acnt;
        logic [7:0] q0;
        logic       v0;
        q0 = q; v0 = valid;
        @(negedge clock);
        clr = 1'b1;
        if (with_req) begin
            req = 1'b1; wren = 1'b1; address = 5'd2; data = 8'h55;
        end
        @(posedge clock); #1;
        clr = 1'b0; req = 1'b0; wren = 1'b0;
        chk({name, " no ack at start"}, ack, 0);
        bcnt = busy ? 1 : 0;
        acnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock); #1;
            if (ack) acnt++;
            if (busy) bcnt++;
            else break;
        end
        chk({name, " busy cycles"}, bcnt, 32);
        chk({name, " ack count"}, acnt, 1);
        chk({name, " q held"}, q, q0);
        chk({name, " valid held"}, valid, v0);
    endtask

    initial begin
        reset = 1'b1; req = 1'b0; wren = 1'b0; address = '0; data = '0; clr = 1'b0;

        vt[0] = '{wr:1'b0, a:5'd5,  d:8'h00, chk_q:1'b0, eq:8'h00, ev:1'b0, ee:1'b0};
        vt[1] = '{wr:1'b1, a:5'd31, d:8'hA7, chk_q:1'b1, eq:8'hA7, ev:1'b1, ee:1'b0};
        vt[2] = '{wr:1'b0, a:5'd31, d:8'h00, chk_q:1'b1, eq:8'hA7, ev:1'b1, ee:1'b0};
        vt[3] = '{wr:1'b1, a:5'd7,  d:8'h11, chk_q:1'b1, eq:8'h11, ev:1'b1, ee:1'b0};
        vt[4] = '{wr:1'b1, a:5'd7,  d:8'h22, chk_q:1'b1, eq:(WP ? 8'h11 : 8'h22), ev:1'b1, ee:WP};
        vt[5] = '{wr:1'b0, a:5'd7,  d:8'h00, chk_q:1'b1, eq:(WP ? 8'h11 : 8'h22), ev:1'b1, ee:1'b0};
        vt[6] = '{wr:1'b1, a:5'd0,  d:8'h3C, chk_q:1'b1, eq:8'h3C, ev:1'b1, ee:1'b0};
        vt[7] = '{wr:1'b0, a:5'd9,  d:8'h00, chk_q:1'b0, eq:8'h00, ev:1'b0, ee:1'b0};

        repeat (2) @(posedge clock);
        #1;
        chk("reset q", q, 0);
        chk("reset valid", valid, 0);
        chk("reset ack", ack, 0);
        chk("reset busy", busy, 0);
        chk("reset err", err, 0);
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            do_op(nm, vt[i].wr, vt[i].a, vt[i].d);
            if (vt[i].chk_q) chk({nm, " q"}, q, vt[i].eq);
            chk({nm, " valid"}, valid, vt[i].ev);
            chk({nm, " err"}, err, vt[i].ee);
            @(posedge clock); #1;
            chk({nm, " ack one cycle"}, ack, 0);
            chk({nm, " err one cycle"}, err, 0);
        end

        // Sweep clears everything written above.
        do_clear("clr", 1'b0);
        do_op("post-clr rd0", 1'b0, 5'd0, 8'h00);
        chk("post-clr rd0 q", q, 8'h00);
        chk("post-clr rd0 valid", valid, 0);
        do_op("post-clr rd31", 1'b0, 5'd31, 8'h00);
        chk("post-clr rd31 q", q, 8'h00);
        chk("post-clr rd31 valid", valid, 0);

        // After a sweep, a word is writable again even with protection.
        do_op("rewrite7", 1'b1, 5'd7, 8'h66);
        chk("rewrite7 q", q, 8'h66);
        chk("rewrite7 err", err, 0);

        // clr and write in the same cycle: sweep wins, write dropped.
        do_clear("clr+req", 1'b1);
        do_op("rd2", 1'b0, 5'd2, 8'h00);
        chk("rd2 valid", valid, 0);
        chk("rd2 q", q, 8'h00);

        // Reset in the middle of a sweep.
        do_op("wr20", 1'b1, 5'd20, 8'h44);
        @(negedge clock);
        clr = 1'b1;
        @(posedge clock); #1;
        clr = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        #1;
        chk("midreset busy", busy, 0);
        chk("midreset ack", ack, 0);
        chk("midreset valid", valid, 0);
        chk("midreset q", q, 0);
        @(posedge clock); #1;
        chk("midreset ack held", ack, 0);
        chk("midreset busy held", busy, 0);
        @(negedge clock);
        reset = 1'b0;
        do_op("rd20", 1'b0, 5'd20, 8'h00);
        chk("rd20 valid", valid, 0);

        // Write request during a read's busy cycle is ignored.
        @(negedge clock);
        req = 1'b1; wren = 1'b0; address = 5'd3;
        @(posedge clock); #1;
        wren = 1'b1; data = 8'h99;
        chk("busy rd in flight", busy, 1);
        @(posedge clock); #1;
        req = 1'b0; wren = 1'b0;
        chk("busy rd ack", ack, 1);
        chk("busy rd valid", valid, 0);
        @(posedge clock); #1;
        chk("ignored wr no ack", ack, 0);
        do_op("rd3", 1'b0, 5'd3, 8'h00);
        chk("rd3 valid", valid, 0);

        // Back-to-back writes then read, issued in ack cycles.
        do_op("b2b wr a", 1'b1, 5'd12, 8'h5A);
        do_op("b2b wr b", 1'b1, 5'd13, 8'hC3);
        chk("b2b wr b q", q, 8'hC3);
        do_op("b2b rd a", 1'b0, 5'd12, 8'h00);
        chk("b2b rd a q", q, 8'h5A);
        chk("b2b rd a valid", valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
